fifo_sched: RTL and testbench

//  Controller that shares one 4x8 fifo between NREQ write requesters and one read consumer.

---
 rtl/fifo_sched_pkg.sv | 27 ++
 rtl/fifo_sched_rr_arbiter.sv | 60 ++++++
 rtl/fifo_sched.sv | 162 ++++++++++++++++
 tb/tb_fifo_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sched_pkg
//  Description : Shared types for the fifo_sched controller: FSM state
//                encodings and the operation tag used for read/write
//                alternation.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_sched_pkg;

  // Controller states. One fifo operation per visit to WRITE or READ.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Last fifo operation performed; decides who wins when both sides are ready.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sched_rr_arbiter
//  Description : Round-robin arbiter for the fifo_sched write requesters.
//                The winner is latched on load and reported on grant; the
//                round-robin pointer advances past the winner on accept.
//  Ports       : pclk/clear - clock and synchronous active-high reset
//                req        - NREQ request lines
//                load       - capture the current winner into grant
//                accept     - latched winner was served; advance pointer
//                grant      - one-hot latched winner
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sched_rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            pclk,
  input  logic            clear,
  input  logic [NREQ-1:0] req,
  input  logic            load,
  input  logic            accept,
  output logic [NREQ-1:0] grant
);

  // Pointer is kept one-hot so the search needs no binary index arithmetic.
  logic [NREQ-1:0] rr_ptr_oh;
  logic [NREQ-1:0] mask_ge;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick_src;
  logic [NREQ-1:0] pick;

  always_comb begin
    // Bits at or above the pointer position.
    mask_ge  = ~(rr_ptr_oh - NREQ'(1));
    masked   = req & mask_ge;
    // Nothing at/after the pointer: wrap around and search from bit 0.
    pick_src = (|masked) ? masked : req;
    // Isolate the lowest set bit.
    pick     = pick_src & (~pick_src + NREQ'(1));
  end

  always_ff @(posedge pclk) begin
    if (clear) begin
      rr_ptr_oh <= NREQ'(1);
      grant     <= '0;
    end else begin
      if (load) begin
        grant <= pick;
      end
      if (accept) begin
        // Next search starts one past the winner, wrapping NREQ-1 -> 0.
        rr_ptr_oh <= {grant[NREQ-2:0], grant[NREQ-1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sched
//  Description : Shares one DEPTH x WIDTH fifo between NREQ round-robin write
//                requesters and one read consumer. Issues at most one fifo
//                operation per cycle, tracks occupancy, and returns popped
//                words on a valid/ack handshake.
//  Ports       : pclk, clear            - clock, synchronous active-high reset
//                wr_req/wr_data/wr_grant - requester side
//                rd_req/rd_valid/rd_data/rd_ack - consumer side
//                f_en/f_write/f_read/f_clear_n/f_wordIn/f_wordOut - fifo side
//                count/full             - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  clear,
  input  logic [NREQ-1:0]       wr_req,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       wr_grant,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ack,
  output logic                  f_en,
  output logic                  f_write,
  output logic                  f_read,
  output logic                  f_clear_n,
  output logic [WIDTH-1:0]      f_wordIn,
  input  logic [WIDTH-1:0]      f_wordOut,
  output logic [2:0]            count,
  output logic                  full
);

  localparam logic [2:0] C_DEPTH = 3'(DEPTH);

  state_t          state;
  state_t          state_nxt;
  op_t             last_op;
  logic            can_wr;
  logic            can_rd;
  logic            take_wr;
  logic [NREQ-1:0] arb_grant;

  assign can_wr  = (|wr_req) && (count < C_DEPTH);
  assign can_rd  = rd_req && (count != 3'd0) && !rd_valid;
  // When both sides are ready, write only if the previous op was a read.
  assign take_wr = can_wr && (!can_rd || (last_op == OP_READ));

  assign full      = (count == C_DEPTH);
  assign f_clear_n = ~clear;

  fifo_sched_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .pclk   (pclk),
    .clear  (clear),
    .req    (wr_req),
    .load   ((state == ST_IDLE) && take_wr),
    .accept (state == ST_WRITE),
    .grant  (arb_grant)
  );

  // Select the granted requester's word (grant is one-hot).
  logic [WIDTH-1:0] word_acc [NREQ+1];
  assign word_acc[0] = {WIDTH{1'b0}};
  for (genvar k = 0; k < NREQ; k++) begin : g_wmux
    assign word_acc[k+1] = word_acc[k] |
                           (arb_grant[k] ? wr_data[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
  end

  // State register
  always_ff @(posedge pclk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_wr) begin
          state_nxt = ST_WRITE;
        end else if (can_rd) begin
          state_nxt = ST_READ;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_READ:  state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_HOLD;
      ST_HOLD:  state_nxt = rd_ack ? ST_IDLE : ST_HOLD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    wr_grant = '0;
    f_en     = 1'b0;
    f_write  = 1'b0;
    f_read   = 1'b0;
    f_wordIn = '0;
    case (state)
      ST_WRITE: begin
        f_en     = 1'b1;
        f_write  = 1'b1;
        wr_grant = arb_grant;
        f_wordIn = word_acc[NREQ];
      end
      ST_READ: begin
        f_en   = 1'b1;
        f_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Occupancy, alternation memory and read-return register. Occupancy moves
  // on the same edge the fifo performs the operation.
  always_ff @(posedge pclk) begin
    if (clear) begin
      count    <= 3'd0;
      last_op  <= OP_READ;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        ST_WRITE: begin
          count   <= count + 3'd1;
          last_op <= OP_WRITE;
        end
        ST_READ: begin
          count   <= count - 3'd1;
          last_op <= OP_READ;
        end
        ST_CAPT: begin
          // The fifo presents the popped word only after the read edge.
          rd_data  <= f_wordOut;
          rd_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (rd_ack) begin
            rd_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_sched
//  Description : Self-checking bench for fifo_sched with a behavioural 4x8
//                fifo attached. Cycle table plus directed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sched;

  logic        pclk = 1'b0;
  logic        clear;
  logic [1:0]  wr_req;
  logic [15:0] wr_data;
  logic [1:0]  wr_grant;
  logic        rd_req;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        f_en;
  logic        f_write;
  logic        f_read;
  logic        f_clear_n;
  logic [7:0]  f_wordIn;
  logic [7:0]  f_wordOut;
  logic [2:0]  count;
  logic        full;

  int passed = 0;
  int total  = 0;

  always #5 pclk = ~pclk;

  fifo_sched #(.NREQ(2), .DEPTH(4), .WIDTH(8)) dut (
    .pclk      (pclk),
    .clear     (clear),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_grant  (wr_grant),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .f_en      (f_en),
    .f_write   (f_write),
    .f_read    (f_read),
    .f_clear_n (f_clear_n),
    .f_wordIn  (f_wordIn),
    .f_wordOut (f_wordOut),
    .count     (count),
    .full      (full)
  );

  // Behavioural 4x8 fifo: word appears on f_wordOut after the read edge.
  logic [7:0] fmem [4];
  logic [1:0] fwp, frp;
  logic [2:0] fcnt;
  always @(posedge pclk) begin
    if (!f_clear_n) begin
      fwp <= 2'd0; frp <= 2'd0; fcnt <= 3'd0; f_wordOut <= 8'h00;
    end else if (f_en && f_write && fcnt != 3'd4) begin
      fmem[fwp] <= f_wordIn; fwp <= fwp + 2'd1; fcnt <= fcnt + 3'd1;
    end else if (f_en && f_read && fcnt != 3'd0) begin
      f_wordOut <= fmem[frp]; frp <= frp + 2'd1; fcnt <= fcnt - 3'd1;
    end
  end

  typedef struct {
    logic       clr;
    logic [1:0] wreq;
    logic [7:0] d0, d1;
    logic       rreq, rack;
    logic [1:0] g;
    logic       en, wr, rd;
    logic [7:0] win;
    logic [2:0] cnt;
    logic       full, vld;
    logic [7:0] rdat;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic clr, input logic [1:0] wreq,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic rreq, input logic rack,
                              input logic [1:0] g, input logic en, input logic wr,
                              input logic rd, input logic [7:0] win,
                              input logic [2:0] cnt, input logic fl,
                              input logic vld, input logic [7:0] rdat);
    vec_t v;
    v.clr = clr; v.wreq = wreq; v.d0 = d0; v.d1 = d1; v.rreq = rreq; v.rack = rack;
    v.g = g; v.en = en; v.wr = wr; v.rd = rd; v.win = win; v.cnt = cnt;
    v.full = fl; v.vld = vld; v.rdat = rdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One read transaction from IDLE: latency and returned word are checked.
  task automatic do_read(input string name, input logic [7:0] exp);
    int lat;
    bit got;
    lat = 0; got = 0;
    rd_req = 1'b1;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge pclk); #3;
      if (rd_valid) begin got = 1; lat = i; end
    end
    rd_req = 1'b0;
    check({name, "_lat"}, 64'(lat), 64'd3);
    check({name, "_data"}, 64'(rd_data), 64'(exp));
    rd_ack = 1'b1;
    @(posedge pclk); #1;
    rd_ack = 1'b0;
  endtask

  initial begin
    logic [26:0] act, exp;
    logic [3:0]  ops;
    int          nops;
    bit          both;
    bit          got;

    // Test 1: single push then read. Test 2/3: alternating grants, fill to full.
    vecs[0]  = mk(0,2'b01,8'hA1,8'h00,0,0, 2'b00,0,0,0,8'h00,3'd0,0,0,8'h00);
    vecs[1]  = mk(0,2'b01,8'hA1,8'h00,1,0, 2'b01,1,1,0,8'hA1,3'd0,0,0,8'h00);
    vecs[2]  = mk(0,2'b00,8'hA1,8'h00,1,0, 2'b00,0,0,0,8'h00,3'd1,0,0,8'h00);
    vecs[3]  = mk(0,2'b00,8'hA1,8'h00,0,0, 2'b00,1,0,1,8'h00,3'd1,0,0,8'h00);
    vecs[4]  = mk(0,2'b00,8'hA1,8'h00,0,0, 2'b00,0,0,0,8'h00,3'd0,0,0,8'h00);
    vecs[5]  = mk(0,2'b00,8'hA1,8'h00,0,0, 2'b00,0,0,0,8'h00,3'd0,0,1,8'hA1);
    vecs[6]  = mk(0,2'b00,8'hA1,8'h00,0,1, 2'b00,0,0,0,8'h00,3'd0,0,1,8'hA1);
    vecs[7]  = mk(0,2'b00,8'hA1,8'h00,0,0, 2'b00,0,0,0,8'h00,3'd0,0,0,8'h00);
    vecs[8]  = mk(1,2'b00,8'h00,8'h00,0,0, 2'b00,0,0,0,8'h00,3'd0,0,0,8'h00);
    vecs[9]  = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd0,0,0,8'h00);
    vecs[10] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b01,1,1,0,8'h10,3'd0,0,0,8'h00);
    vecs[11] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd1,0,0,8'h00);
    vecs[12] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b10,1,1,0,8'h20,3'd1,0,0,8'h00);
    vecs[13] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd2,0,0,8'h00);
    vecs[14] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b01,1,1,0,8'h10,3'd2,0,0,8'h00);
    vecs[15] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd3,0,0,8'h00);
    vecs[16] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b10,1,1,0,8'h20,3'd3,0,0,8'h00);
    vecs[17] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd4,1,0,8'h00);
    vecs[18] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd4,1,0,8'h00);
    vecs[19] = mk(0,2'b11,8'h10,8'h20,1,0, 2'b00,0,0,0,8'h00,3'd4,1,0,8'h00);
    vecs[20] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,1,0,1,8'h00,3'd4,1,0,8'h00);
    vecs[21] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd3,0,0,8'h00);
    vecs[22] = mk(0,2'b11,8'h10,8'h20,0,1, 2'b00,0,0,0,8'h00,3'd3,0,1,8'h10);
    vecs[23] = mk(0,2'b11,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd3,0,0,8'h00);
    vecs[24] = mk(0,2'b01,8'h10,8'h20,0,0, 2'b01,1,1,0,8'h10,3'd3,0,0,8'h00);
    vecs[25] = mk(0,2'b00,8'h10,8'h20,0,0, 2'b00,0,0,0,8'h00,3'd4,1,0,8'h00);

    clear = 1'b1; wr_req = 2'b00; wr_data = 16'h0000; rd_req = 1'b0; rd_ack = 1'b0;
    repeat (2) @(posedge pclk);
    #3;
    check("reset", 64'({f_clear_n, wr_grant, f_en, f_write, f_read, f_wordIn,
                        count, full, rd_valid, rd_data}), 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(posedge pclk); #1;
      clear   = vecs[i].clr;
      wr_req  = vecs[i].wreq;
      wr_data = {vecs[i].d1, vecs[i].d0};
      rd_req  = vecs[i].rreq;
      rd_ack  = vecs[i].rack;
      #2;
      act = {f_clear_n, wr_grant, f_en, f_write, f_read,
             (vecs[i].wr ? f_wordIn : 8'h00), count, full, rd_valid,
             (vecs[i].vld ? rd_data : 8'h00)};
      exp = {~vecs[i].clr, vecs[i].g, vecs[i].en, vecs[i].wr, vecs[i].rd,
             vecs[i].win, vecs[i].cnt, vecs[i].full, vecs[i].vld, vecs[i].rdat};
      check($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end

    // Drain in push order: 10,20,10,20 pushed, 10 popped, 10 pushed again.
    do_read("drain0", 8'h20);
    do_read("drain1", 8'h10);
    do_read("drain2", 8'h20);
    do_read("drain3", 8'h10);
    #2;
    check("drain_count", 64'(count), 64'd0);

    // Test 5: reads blocked when empty; stray ack ignored.
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) rd_ack = 1'b1;
      @(posedge pclk); #3;
      check($sformatf("empty_rd%0d", i), 64'({f_read, f_en, rd_valid, count}), 64'd0);
    end
    rd_req = 1'b0; rd_ack = 1'b0;

    // Test 4: count=2 with last op READ, then both sides held -> W,R,W,R.
    wr_req = 2'b01; wr_data = 16'h0055;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge pclk); #3;
      if (count == 3'd3) got = 1;
    end
    wr_req = 2'b00;
    check("fill3", 64'(count), 64'd3);
    do_read("pre_alt", 8'h55);
    #2;
    wr_req = 2'b01; wr_data = 16'h0066; rd_req = 1'b1; rd_ack = 1'b1;
    ops = 4'b0000; nops = 0; both = 0;
    for (int i = 0; i < 40 && nops < 4; i++) begin
      @(posedge pclk); #3;
      if (f_en) begin
        ops = {ops[2:0], f_write};
        nops++;
        if (f_write && f_read) both = 1;
      end
    end
    rd_req = 1'b0; wr_req = 2'b00;
    check("alt_ops", 64'(ops), 64'(4'b1010));
    check("alt_no_both", 64'(both), 64'd0);
    repeat (4) @(posedge pclk);
    #1 rd_ack = 1'b0;
    #2;
    check("alt_count", 64'(count), 64'd2);

    // Test 6: clear while capturing a read.
    rd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge pclk); #3;
      if (f_read) got = 1;
    end
    rd_req = 1'b0;
    check("clr_saw_read", 64'(got), 64'd1);
    @(posedge pclk); #1;
    clear = 1'b1;
    #2;
    check("clr_fclear_n", 64'(f_clear_n), 64'd0);
    @(posedge pclk); #1;
    clear = 1'b0;
    #2;
    check("clr_state", 64'({rd_valid, rd_data, count, full, f_en}), 64'd0);
    check("clr_fifo_empty", 64'(fcnt != 3'd0), 64'd0);
    wr_req = 2'b11; wr_data = 16'h8877;
    @(posedge pclk); #3;
    check("clr_rr_reset", 64'({wr_grant, f_wordIn}), 64'({2'b01, 8'h77}));
    wr_req = 2'b00;
    @(posedge pclk); #3;
    check("clr_push_count", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
